// File: rtl/moore_seq_pkg.sv
// Shared constants and elaboration-time helpers for the Moore sequence detector.
package moore_seq_pkg;

  localparam int NON_OVL = 0;
  localparam int OVL     = 1;

  localparam int                   DEF_PAT_W   = 3;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b101;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  // Pattern bit i (i = 0 is the first bit expected) lives at pat[pat_w-1-i].
  function automatic int fail_next(input logic [15:0] pat, input int pat_w,
                                   input int k, input logic b);
    int   best;
    int   p;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j <= pat_w; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          p  = k + 1 - j + t;
          sb = (p == k) ? b : pat[pat_w-1-p];
          if (sb != pat[pat_w-1-t]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/moore_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module moore_seq_sat_cnt
  import moore_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/moore_seq_detect.sv
// Moore serial pattern detector with a full failure-function next-state table.
// Define MOORE_SEQ_CNT_EN to build the detection counter; otherwise det_count is 0.
module moore_seq_detect
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               OVERLAP = NON_OVL,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data_in,
  input  logic             cnt_clr,
  output logic             data_out,
  output logic [CNT_W-1:0] det_count
);

  localparam int SW      = state_w(PAT_W);
  localparam int NUM_ENC = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t S_LAST = state_t'(PAT_W);

  logic [NUM_ENC-1:0][SW-1:0] nxt0;
  logic [NUM_ENC-1:0][SW-1:0] nxt1;
  logic [NUM_ENC-1:0]         state_valid;

  state_t state_reg;
  state_t state_next;
  logic   data_out_reg;

  // Transition table resolved at elaboration; the full-match row depends on OVERLAP.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENC; gi++) begin : g_tbl
      if (gi < PAT_W) begin : g_partial
        localparam int N0 = fail_next(16'(PATTERN), PAT_W, gi, 1'b0);
        localparam int N1 = fail_next(16'(PATTERN), PAT_W, gi, 1'b1);
        assign nxt0[gi]        = state_t'(N0);
        assign nxt1[gi]        = state_t'(N1);
        assign state_valid[gi] = 1'b1;
      end else if (gi == PAT_W) begin : g_full
        localparam int K  = (OVERLAP == OVL) ? PAT_W : 0;
        localparam int N0 = fail_next(16'(PATTERN), PAT_W, K, 1'b0);
        localparam int N1 = fail_next(16'(PATTERN), PAT_W, K, 1'b1);
        assign nxt0[gi]        = state_t'(N0);
        assign nxt1[gi]        = state_t'(N1);
        assign state_valid[gi] = 1'b1;
      end else begin : g_unused
        assign nxt0[gi]        = '0;
        assign nxt1[gi]        = '0;
        assign state_valid[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (!state_valid[state_reg]) begin
      state_next = '0;
    end else if (en) begin
      state_next = data_in ? nxt1[state_reg] : nxt0[state_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= '0;
      data_out_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_out_reg <= (state_next == S_LAST);
    end
  end

  assign data_out = data_out_reg;

`ifdef MOORE_SEQ_CNT_EN
  logic det_inc;
  assign det_inc = en && (state_next == S_LAST);

  moore_seq_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (det_inc),
    .clr  (cnt_clr),
    .count(det_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign det_count      = '0;
`endif

endmodule

// File: doc/moore_seq_detect.md
MOORE_SEQ_DETECT -- requirements
Module: moore_seq_detect

Interface
REQ-001 SHALL have parameter PAT_W, default 3: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 3'b101: target sequence; PATTERN[PAT_W-1] is the first bit expected.
REQ-003 SHALL have parameter OVERLAP, default 0: 0 = non-overlapping detection, 1 = overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8: detection-counter width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: sample qualifier; data_in is consumed only when en=1.
REQ-008 SHALL have port data_in, input, 1 bit: serial input bit.
REQ-009 SHALL have port cnt_clr, input, 1 bit: synchronous clear of det_count.
REQ-010 SHALL have port data_out, output, 1 bit: Moore detect flag.
REQ-011 SHALL have port det_count, output, CNT_W bits: number of detections.

Function
REQ-012 SHALL implement PAT_W+1 states S0..S_PAT_W, where Sk = k leading pattern bits matched; state register width $clog2(PAT_W+1).
REQ-013 SHALL drive data_out=1 only in state S_PAT_W, as a function of state only; no combinational path from data_in to data_out.
REQ-014 When en=1 in Sk (k<PAT_W), next state SHALL be the longest pattern prefix that is a suffix of (the k matched bits followed by data_in), i.e. a full failure-function transition, not a blind return to S0.
REQ-015 When en=1 in S_PAT_W with OVERLAP=0, next state SHALL be S1 if data_in==PATTERN[PAT_W-1], else S0.
REQ-016 When en=1 in S_PAT_W with OVERLAP=1, next state SHALL follow the REQ-014 rule applied to the full matched pattern.
REQ-017 When en=0, state SHALL hold; data_out therefore holds.
REQ-018 Latency: data_out SHALL rise on the clock edge that samples the last pattern bit, and is visible in the following cycle.
REQ-019 det_count SHALL increment by 1 on each transition into S_PAT_W, and SHALL saturate at all-ones.
REQ-020 cnt_clr=1 SHALL set det_count to 0 on the next edge; if cnt_clr coincides with entry into S_PAT_W, the clear wins and det_count=0.
REQ-021 Unused state encodings SHALL transition to S0 on the next edge.

Reset
REQ-022 rst_n=0 SHALL immediately force state=S0, data_out=0, det_count=0, independent of clk.
REQ-023 Reset asserted mid-sequence SHALL discard partial matches; the first edge after deassertion evaluates from S0.

Configuration
REQ-024 With macro MOORE_SEQ_CNT_EN defined, the detection counter and cnt_clr logic SHALL be present as in REQ-019 and REQ-020.
REQ-025 Without MOORE_SEQ_CNT_EN, det_count SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL be inferred; the port list is unchanged.

Structure
REQ-026 Shared package moore_seq_pkg SHALL hold the state-width function (clog2), the OVERLAP mode constants (NON_OVL=0, OVL=1), and default PATTERN/PAT_W constants.
REQ-027 The saturating counter SHALL be a sub-module, moore_seq_sat_cnt (parameter CNT_W; ports inc, clr; output count).

Verification
REQ-028 Default params, en=1, data_in 1,0,1,0,1 -> data_out high one cycle after the 3rd bit; low after the 4th; no second detect after the 5th (non-overlap); det_count=1.
REQ-029 OVERLAP=1, same stimulus -> data_out high after the 3rd bit and again after the 5th; det_count=2.
REQ-030 PAT_W=4, PATTERN=4'b1101, stream 1,1,1,0,1 -> detect after the 5th bit, which requires the S2 self-retention failure path; det_count=1.
REQ-031 Default params, bits 1,0 then en=0 for 3 cycles with data_in toggling, then en=1 and data_in=1 -> state holds through the gap; data_out rises after the final 1.
REQ-032 CNT_W=2 with 5 detections -> det_count saturates at 3; cnt_clr asserted in the same cycle as a detect entry -> det_count=0.
REQ-033 rst_n pulsed low between clock edges mid-pattern (after 1,0) -> data_out=0 and det_count=0 immediately; a following single 1 does not detect.
